io_input_buffer: RTL and testbench

Input-side I/O buffer feeding the processor's memory-mapped input port (the 16-bit `read_in` word consumed by the memory stage). It accepts words from an external source over a valid/ready handshake and queues them in a small FIFO. It presents the oldest word to the processor and pops it when the processor's control signals an I/O read. This decouples external producers from the multicycle datapath, which may take several cycles between input reads.

---
 rtl/io_input_buffer.sv | 58 +++++
 tb/tb_io_input_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/io_input_buffer.sv
// io_input_buffer: valid/ready input FIFO presenting the oldest word on read_in for the processor.
// Define IO_BUF_UNDERFLOW_CNT_EN to add the saturating underflow_cnt port.
module io_input_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         ext_data,
  input  logic                     ext_valid,
  output logic                     ext_ready,
  input  logic                     rd_strobe,
  output logic [WIDTH-1:0]         read_in,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
`ifdef IO_BUF_UNDERFLOW_CNT_EN
  ,
  output logic [7:0]               underflow_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic rdy_en, push, pop;
  always_comb begin
    empty = count == '0;
    full = count == (AW+1)'(DEPTH);
    ext_ready = rdy_en && !full;
    push = ext_valid && ext_ready;
    pop = rd_strobe && !empty;
    read_in = empty ? '0 : mem[rp];
  end
  // rdy_en holds off the source for the first edge after reset release
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      rdy_en <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        mem[wp] <= ext_data;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      if (push != pop) count <= push ? count + (AW+1)'(1) : count - (AW+1)'(1);
    end
  end
`ifdef IO_BUF_UNDERFLOW_CNT_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) underflow_cnt <= '0;
    else if (rd_strobe && empty && underflow_cnt != 8'hff) underflow_cnt <= underflow_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_io_input_buffer.sv
// tb_io_input_buffer: randomized and directed checks of io_input_buffer against a queue model.
module tb_io_input_buffer;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic [15:0] ext_data = '0;
  logic ext_valid = 1'b0;
  logic rd_strobe = 1'b0;
  logic ext_ready, empty, full;
  logic [15:0] read_in;
  logic [2:0] count;
  logic [7:0] uf;
  int total = 0;
  int bad = 0;
  logic [15:0] q[$];
  bit m_rdy = 1'b0;
  int m_uf = 0;

  io_input_buffer #(.DEPTH(DEPTH), .WIDTH(16)) dut (
    .clock(clock), .rst(rst), .ext_data(ext_data), .ext_valid(ext_valid),
    .ext_ready(ext_ready), .rd_strobe(rd_strobe), .read_in(read_in),
    .empty(empty), .full(full), .count(count)
`ifdef IO_BUF_UNDERFLOW_CNT_EN
    , .underflow_cnt(uf)
`endif
  );
`ifndef IO_BUF_UNDERFLOW_CNT_EN
  assign uf = '0;
`endif

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: queue of words, ready gate, saturating underflow count
  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_rdy = 1'b0;
      m_uf = 0;
    end else begin
      bit do_push, do_pop;
      do_push = ext_valid && m_rdy && q.size() < DEPTH;
      do_pop = rd_strobe && q.size() > 0;
      if (rd_strobe && q.size() == 0 && m_uf < 255) m_uf++;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ext_data);
      m_rdy = 1'b1;
    end
  end

  always @(negedge clock) begin
    chk("ext_ready", 32'(ext_ready), 32'(m_rdy && q.size() < DEPTH));
    chk("read_in", 32'(read_in), q.size() > 0 ? 32'(q[0]) : 32'd0);
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("count", 32'(count), 32'(q.size()));
`ifdef IO_BUF_UNDERFLOW_CNT_EN
    chk("underflow_cnt", 32'(uf), 32'(m_uf));
`endif
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    ext_valid = 1'b1;
    ext_data = w;
    tick();
    ext_valid = 1'b0;
  endtask

  task automatic pop();
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic async_reset();
    @(posedge clock);
    #3 rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(ext_ready), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_uf", 32'(uf), 32'd0);
    @(negedge clock);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("lit_reset_ready", 32'(ext_ready), 32'd0);
    chk("lit_reset_empty", 32'(empty), 32'd1);
    chk("lit_reset_read_in", 32'(read_in), 32'd0);
    @(negedge clock);
    rst = 1'b1;
    #1 chk("lit_ready_pre_edge", 32'(ext_ready), 32'd0);
    tick();
    chk("lit_ready_after_edge", 32'(ext_ready), 32'd1);
    ext_valid = 1'b1;
    ext_data = 16'h1111;
    tick();
    chk("lit_latency", 32'(read_in), 32'h1111);
    ext_data = 16'h2222;
    tick();
    ext_data = 16'h3333;
    tick();
    ext_valid = 1'b0;
    pop();
    chk("lit_order1", 32'(read_in), 32'h2222);
    pop();
    chk("lit_order2", 32'(read_in), 32'h3333);
    pop();
    chk("lit_order3", 32'(read_in), 32'h0000);
    chk("lit_count0", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) push(16'hA000 + 16'(i));
    ext_valid = 1'b1;
    ext_data = 16'hBEEF;
    tick();
    tick();
    ext_valid = 1'b0;
    chk("lit_full", 32'(full), 32'd1);
    chk("lit_full_ready", 32'(ext_ready), 32'd0);
    chk("lit_full_count", 32'(count), 32'd4);
    repeat (3) pop();
    chk("lit_no_beef", 32'(read_in), 32'hA003);
    pop();
    push(16'hC000);
    push(16'hC001);
    ext_valid = 1'b1;
    ext_data = 16'hC002;
    rd_strobe = 1'b1;
    tick();
    ext_valid = 1'b0;
    rd_strobe = 1'b0;
    chk("lit_simul_count", 32'(count), 32'd2);
    chk("lit_simul_head", 32'(read_in), 32'hC001);
    push(16'hC003);
    push(16'hC004);
    chk("lit_refull", 32'(count), 32'd4);
    ext_valid = 1'b1;
    ext_data = 16'hDEAD;
    rd_strobe = 1'b1;
    tick();
    ext_valid = 1'b0;
    rd_strobe = 1'b0;
    chk("lit_full_pop_count", 32'(count), 32'd3);
    chk("lit_full_pop_head", 32'(read_in), 32'hC002);
    repeat (3) pop();
    chk("lit_no_dead", 32'(empty), 32'd1);
    for (int i = 0; i < 10; i++) begin
      push(16'h5A00 + 16'(i));
      chk("lit_wrap", 32'(read_in), 32'h5A00 + 32'(i));
      pop();
    end
`ifdef IO_BUF_UNDERFLOW_CNT_EN
    async_reset();
    repeat (3) pop();
    chk("lit_uf3", 32'(uf), 32'd3);
`endif
    push(16'h7001);
    push(16'h7002);
    async_reset();
`ifdef IO_BUF_UNDERFLOW_CNT_EN
    rd_strobe = 1'b1;
    repeat (300) tick();
    rd_strobe = 1'b0;
    chk("lit_uf_sat", 32'(uf), 32'd255);
    async_reset();
`endif
    for (int i = 0; i < 2000; i++) begin
      ext_valid = 1'($urandom_range(0, 99) < 60);
      ext_data = 16'($urandom);
      rd_strobe = 1'($urandom_range(0, 99) < 45);
      tick();
      if (i == 1000) begin
        ext_valid = 1'b0;
        rd_strobe = 1'b0;
        async_reset();
      end
    end
    ext_valid = 1'b0;
    rd_strobe = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
